// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants plus the loader and UART receiver state types.
package sap1_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int WE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic is_last_addr(input logic [ADDR_W-1:0] a);
        return a == ADDR_W'(MEM_DEPTH - 1);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchroniser and mid-bit sampling.
// The received byte port is rx_byte because "byte" is a reserved word.
module uart_rx
    import sap1_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);

    logic       meta_q, sync_q, prev_q;
    rx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    // The counter restarts on every phase change so each sample lands mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives 16 bytes over UART and writes them to RAM 0..15.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module prog_loader
    import sap1_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              start,
    input  logic              rx,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              nWE,
    output logic              CS,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int WCNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              chk_q, chk_d;
`endif

    uart_rx #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .CLR        (CLR),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // start wins over everything, including a byte arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RECV;
        end else begin
            unique case (state_q)
                ST_RECV: begin
                    if (frame_err) begin
                        state_d = ST_ERROR;
                    end else if (byte_valid) begin
                        state_d = ST_WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (chk_q) state_d = (rx_byte == sum_q) ? ST_DONE : ST_ERROR;
`endif
                    end
                end
                ST_WRITE: begin
                    if (byte_valid)                                state_d = ST_ERROR;
                    else if (wcnt_q == WCNT_W'(WE_CYCLES - 1))     state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (byte_valid) begin
                        state_d = ST_ERROR;
                    end else if (is_last_addr(addr_q)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_RECV;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_RECV;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        nWE  = 1'b1;
        CS   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        unique case (state_q)
            ST_RECV:  busy = 1'b1;
            ST_WRITE: begin busy = 1'b1; CS = 1'b1; nWE = 1'b0; end
            ST_HOLD:  begin busy = 1'b1; CS = 1'b1; end
            ST_DONE:  done = 1'b1;
            ST_ERROR: err  = 1'b1;
            default:  ;
        endcase
    end

    // Address advances only as HOLD is left, so addr/data stay put through the strobe.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wcnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d  = sum_q;
        chk_d  = chk_q;
`endif
        if (start) begin
            addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d  = '0;
            chk_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_RECV: begin
                    if (byte_valid && !frame_err) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (!chk_q) begin
                            data_d = rx_byte;
                            sum_d  = sum_q + rx_byte;
                        end
`else
                        data_d = rx_byte;
`endif
                    end
                end
                ST_WRITE: wcnt_d = wcnt_q + 1'b1;
                ST_HOLD: begin
                    if (!byte_valid) begin
                        if (!is_last_addr(addr_q)) addr_d = addr_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        else chk_d = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            addr_q <= '0;
            data_q <= '0;
            wcnt_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q  <= '0;
            chk_q  <= 1'b0;
`endif
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            wcnt_q <= wcnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q  <= sum_d;
            chk_q  <= chk_d;
`endif
        end
    end

    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader; a negedge monitor logs every RAM write strobe.
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
module tb_prog_loader;

    localparam int CLK_HZ = 3686400;
    localparam int BAUD   = 115200;
    localparam int DIV    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       CLR;
    logic       start;
    logic       rx;
    logic [3:0] addr;
    logic [7:0] data;
    logic       nWE, CS, busy, done, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         len;
        logic       hold;
    } wr_t;

    wr_t        writes[$];
    int         run = 0;
    logic [3:0] capA;
    logic [7:0] capD;
    bit         unstable = 0;

    prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .CLR   (CLR),
        .start (start),
        .rx    (rx),
        .addr  (addr),
        .data  (data),
        .nWE   (nWE),
        .CS    (CS),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Each strobe is logged with its address, data, low length and whether CS survived into the hold cycle.
    always @(negedge clk) begin
        if (!nWE) begin
            if (run == 0) begin
                capA = addr;
                capD = data;
            end else if (addr !== capA || data !== capD || CS !== 1'b1) begin
                unstable = 1;
            end
            run++;
        end else if (run != 0) begin
            writes.push_back('{capA, capD, unstable ? -1 : run, CS});
            run      = 0;
            unstable = 0;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stopBit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        CLR   = 1'b1;
        start = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (addr !== 4'd0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", addr); end
        total++; if (data !== 8'd0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", data); end
        total++; if (nWE !== 1'b1) begin bad++; $display("[TB] FAIL reset_nWE got=%b want=1", nWE); end
        total++; if (CS !== 1'b0) begin bad++; $display("[TB] FAIL reset_CS got=%b want=0", CS); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {busy, done, err}); end
        CLR = 1'b0;
        repeat (3) @(negedge clk);
        writes.delete();
        send_byte(8'($urandom), 1'b1);
        repeat (10) @(negedge clk);
        total++; if (writes.size() !== 0) begin bad++; $display("[TB] FAIL idle_ignores_rx writes got=%0d want=0", writes.size()); end
        total++; if ({busy, CS, nWE} !== 3'b001) begin bad++; $display("[TB] FAIL idle_outputs got=%b want=001", {busy, CS, nWE}); end
    endtask

    task automatic test_load(input logic [7:0] pat[16], input string tag);
        logic [7:0] sum;
        sum = 8'd0;
        writes.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(pat[i], 1'b1);
            sum = sum + pat[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(sum, 1'b1);
`endif
        for (int k = 0; k < 400 && !(done || err); k++) @(negedge clk);
        total++;
        if (writes.size() !== 16) begin
            bad++; $display("[TB] FAIL %s write_count got=%0d want=16", tag, writes.size());
        end
        for (int i = 0; i < writes.size() && i < 16; i++) begin
            total++;
            if (writes[i].a !== 4'(i) || writes[i].d !== pat[i] || writes[i].len != 4 || writes[i].hold !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s write%0d got a=%h d=%h len=%0d hold=%b want a=%h d=%h len=4 hold=1",
                         tag, i, writes[i].a, writes[i].d, writes[i].len, writes[i].hold, 4'(i), pat[i]);
            end
        end
        total++;
        if ({done, err, busy, CS, nWE} !== 5'b10001) begin
            bad++; $display("[TB] FAIL %s end_flags done,err,busy,CS,nWE got=%b want=10001", tag, {done, err, busy, CS, nWE});
        end
    endtask

    task automatic test_full_load();
        logic [7:0] pat[16];
        for (int i = 0; i < 16; i++) pat[i] = 8'(8'h1E + 8'h11 * i);
        test_load(pat, "full_load");
    endtask

    task automatic test_random_load(input string tag);
        logic [7:0] pat[16];
        for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
        test_load(pat, tag);
    endtask

    task automatic test_framing();
        logic [7:0] pat[3];
        writes.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            pat[i] = 8'($urandom);
            send_byte(pat[i], 1'b1);
        end
        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        total++; if (writes.size() !== 3) begin bad++; $display("[TB] FAIL framing_writes got=%0d want=3", writes.size()); end
        for (int i = 0; i < writes.size() && i < 3; i++) begin
            total++;
            if (writes[i].a !== 4'(i) || writes[i].d !== pat[i]) begin
                bad++; $display("[TB] FAIL framing_write%0d got a=%h d=%h want a=%h d=%h", i, writes[i].a, writes[i].d, 4'(i), pat[i]);
            end
        end
        total++;
        if ({err, done, busy, CS, nWE} !== 5'b10001) begin
            bad++; $display("[TB] FAIL framing_flags err,done,busy,CS,nWE got=%b want=10001", {err, done, busy, CS, nWE});
        end
        send_byte(8'($urandom), 1'b1);
        total++;
        if (writes.size() !== 3 || err !== 1'b1) begin
            bad++; $display("[TB] FAIL error_sticky writes=%0d err=%b want writes=3 err=1", writes.size(), err);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        writes.delete();
        pulse_start();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        total++; if (writes.size() !== 0) begin bad++; $display("[TB] FAIL glitch_writes got=%0d want=0", writes.size()); end
        total++;
        if ({busy, CS, nWE, err, done} !== 5'b10100) begin
            bad++; $display("[TB] FAIL glitch_state busy,CS,nWE,err,done got=%b want=10100", {busy, CS, nWE, err, done});
        end
        b = 8'($urandom);
        send_byte(b, 1'b1);
        total++;
        if (writes.size() !== 1 || writes[0].a !== 4'd0 || writes[0].d !== b) begin
            bad++; $display("[TB] FAIL glitch_recover writes=%0d want 1 write of %h at 0", writes.size(), b);
        end
    endtask

    task automatic test_clr_mid_write();
        logic [7:0] pat[8];
        bit hit;
        hit = 0;
        writes.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
        for (int i = 0; i < 7; i++) send_byte(pat[i], 1'b1);
        fork
            send_byte(pat[7], 1'b1);
            begin
                for (int k = 0; k < 12 * DIV; k++) begin
                    @(negedge clk);
                    if (!nWE && addr == 4'd7) begin
                        hit = 1;
                        break;
                    end
                end
                if (hit) begin
                    #2 CLR = 1'b1;
                    #1;
                    total++;
                    if ({nWE, CS, busy, addr} !== {3'b100, 4'd0}) begin
                        bad++; $display("[TB] FAIL clr_async nWE,CS,busy,addr got=%b want=1000000", {nWE, CS, busy, addr});
                    end
                end else begin
                    total++; bad++;
                    $display("[TB] FAIL clr_wait no write at addr 7 got=0 want=1");
                end
            end
        join
        @(negedge clk);
        CLR = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (writes.size() < 7 || writes[6].a !== 4'd6 || writes[6].d !== pat[6]) begin
            bad++; $display("[TB] FAIL clr_prior_writes got=%0d want>=7", writes.size());
        end
        total++;
        if ({done, err, busy} !== 3'b000) begin
            bad++; $display("[TB] FAIL clr_idle done,err,busy got=%b want=000", {done, err, busy});
        end
        test_random_load("reload_after_clr");
    endtask

    task automatic test_start_collision();
        logic [7:0] b;
        bit hit;
        hit = 0;
        writes.delete();
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1);
        fork
            send_byte(8'($urandom), 1'b1);
            begin
                for (int k = 0; k < 12 * DIV; k++) begin
                    @(negedge clk);
                    if (dut.u_rx.byte_valid) begin
                        hit = 1;
                        break;
                    end
                end
                start = hit;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        total++; if (!hit) begin bad++; $display("[TB] FAIL collide_wait byte_valid seen=0 want=1"); end
        total++; if (writes.size() !== 9) begin bad++; $display("[TB] FAIL collide_writes got=%0d want=9", writes.size()); end
        total++;
        if ({addr, err, done, busy} !== {4'd0, 3'b001}) begin
            bad++; $display("[TB] FAIL collide_state addr=%h err=%b done=%b busy=%b want addr=0 err=0 done=0 busy=1", addr, err, done, busy);
        end
        b = 8'($urandom);
        send_byte(b, 1'b1);
        total++;
        if (writes.size() !== 10 || writes[9].a !== 4'd0 || writes[9].d !== b) begin
            bad++; $display("[TB] FAIL collide_reload writes=%0d want 10th write of %h at addr 0", writes.size(), b);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] pat[16];
        for (int i = 0; i < 16; i++) pat[i] = 8'h10;
        test_load(pat, "checksum_match");
        writes.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'h10, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (10) @(negedge clk);
        total++; if (writes.size() !== 16) begin bad++; $display("[TB] FAIL checksum_bad_writes got=%0d want=16", writes.size()); end
        total++;
        if ({err, done, CS} !== 3'b100) begin
            bad++; $display("[TB] FAIL checksum_bad_flags err,done,CS got=%b want=100", {err, done, CS});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_random_load("random_load_a");
        test_framing();
        test_glitch();
        test_clr_mid_write();
        test_start_collision();
        test_random_load("random_load_b");
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
